// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message-schedule sequencer.
//   SHA256_WORD_W / SHA256_BLK_W / SHA256_ROUNDS : word, block and round sizes
//   sha256_s0 / sha256_s1                        : small-sigma functions of the schedule
//   sched_state_t                                : sequencer FSM states
package sha256_pkg;

    localparam int SHA256_WORD_W = 32;
    localparam int SHA256_BLK_W  = 512;
    localparam int SHA256_ROUNDS = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    // s0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [SHA256_WORD_W-1:0] sha256_s0(input logic [SHA256_WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // s1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [SHA256_WORD_W-1:0] sha256_s1(input logic [SHA256_WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_step.sv
// One step of the SHA-256 schedule recurrence (purely combinational).
//   w_t    : W_(t)       w_t1  : W_(t+1)
//   w_t9   : W_(t+9)     w_t14 : W_(t+14)
//   w_t16  : W_(t+16) = s1(w_t14) + w_t9 + s0(w_t1) + w_t   (mod 2^32)
module sha256_w_step
    import sha256_pkg::*;
(
    input  logic [SHA256_WORD_W-1:0] w_t,
    input  logic [SHA256_WORD_W-1:0] w_t1,
    input  logic [SHA256_WORD_W-1:0] w_t9,
    input  logic [SHA256_WORD_W-1:0] w_t14,
    output logic [SHA256_WORD_W-1:0] w_t16
);

    // Carries beyond bit 31 fall off because the sum is sized to the word.
    assign w_t16 = sha256_s1(w_t14) + w_t9 + sha256_s0(w_t1) + w_t;

endmodule

// File: rtl/sha256_w_sched_ctrl.sv
// Serial SHA-256 message-schedule sequencer.
// Accepts one 512-bit padded block and streams W_0..W_(ROUNDS-1), one word per
// output handshake, from a 16-word sliding window.
//   CLK, RST   : clock; synchronous active-high reset
//   abort      : flush the block in progress (no effect in IDLE except blocking acceptance)
//   in_valid / in_ready / block_in     : block input ([511:480] = W_0 ... [31:0] = W_15)
//   out_valid / out_ready / out_w / out_idx / out_last : word output stream
//   busy       : high while a block is being sequenced (state RUN)
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid never depends on ready, and a valid word holds stable until it transfers
// (or the block is aborted/reset).
module sha256_w_sched_ctrl
    import sha256_pkg::*;
#(
    parameter int ROUNDS = SHA256_ROUNDS,   // 17..64
    parameter int IDX_W  = 6                // 2**IDX_W >= ROUNDS
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SHA256_BLK_W-1:0]  block_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SHA256_WORD_W-1:0] out_w,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic                     busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    sched_state_t              state;
    logic [SHA256_WORD_W-1:0]  win [16];
    logic [SHA256_WORD_W-1:0]  w_next;
    logic                      accept;
    logic                      beat;
    logic                      load_en;
    logic                      shift_en;
    logic [IDX_W-1:0]          idx_next;

    assign accept   = (state == IDLE) && in_valid && in_ready && !abort;
    assign beat     = (state == RUN) && out_valid && out_ready && !abort;
    // Window is not reset (contents are don't-care), so gate its enables with RST
    // to keep a reset cycle from disturbing it.
    assign load_en  = accept && !RST;
    assign shift_en = beat && !RST;
    // out_idx doubles as the word counter.
    assign idx_next = out_idx + IDX_W'(1);

    sha256_w_step u_step (
        .w_t   (win[0]),
        .w_t1  (win[1]),
        .w_t9  (win[9]),
        .w_t14 (win[14]),
        .w_t16 (w_next)
    );

    // Sliding window: win[0] always holds the word currently presented on out_w.
    always_ff @(posedge CLK) begin
        if (load_en) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= block_in[SHA256_BLK_W-1-32*i -: 32];
            end
        end else if (shift_en) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i+1];
            end
            win[15] <= w_next;
        end
    end

    // FSM and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_w     <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= RUN;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_w     <= block_in[SHA256_BLK_W-1 -: 32];
                        out_idx   <= '0;
                        out_last  <= 1'b0;   // ROUNDS >= 17, so word 0 is never last
                    end
                end
                RUN: begin
                    if (abort || (beat && out_last)) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        out_last  <= 1'b0;
                    end else if (beat) begin
                        out_w    <= win[1];
                        out_idx  <= idx_next;
                        out_last <= (idx_next == LAST_IDX);
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_w_sched_ctrl.sv
module tb_sha256_w_sched_ctrl;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          abort = 1'b0;
    logic [511:0]  block_in = '0;

    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_w;
    logic [5:0]    out_idx;
    logic          out_last;
    logic          busy;

    logic          in_valid17 = 1'b0;
    logic          in_ready17;
    logic          out_valid17;
    logic          out_ready17 = 1'b0;
    logic [31:0]   out_w17;
    logic [4:0]    out_idx17;
    logic          out_last17;
    logic          busy17;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mw [64];
    logic [31:0] got_w [64];

    typedef struct {
        int          idx;
        logic [31:0] w;
    } hand_vec_t;

    typedef struct {
        logic [511:0] blk;
        int           mode;   // 0: ready high, 1: ready 1010..., 2: random ready
    } run_vec_t;

    hand_vec_t hand_tbl [7];
    run_vec_t  run_tbl [4];

    always #5 CLK = ~CLK;

    sha256_w_sched_ctrl #(.ROUNDS(64), .IDX_W(6)) dut (
        .CLK(CLK), .RST(RST), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .block_in(block_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    sha256_w_sched_ctrl #(.ROUNDS(17), .IDX_W(5)) dut17 (
        .CLK(CLK), .RST(RST), .abort(abort),
        .in_valid(in_valid17), .in_ready(in_ready17), .block_in(block_in),
        .out_valid(out_valid17), .out_ready(out_ready17), .out_w(out_w17),
        .out_idx(out_idx17), .out_last(out_last17), .busy(busy17)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Independent reference: full 64-entry schedule array.
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic fill_model(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) mw[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            mw[t] = (ror(mw[t-2], 17) ^ ror(mw[t-2], 19) ^ (mw[t-2] >> 10))
                  + mw[t-7]
                  + (ror(mw[t-15], 7) ^ ror(mw[t-15], 18) ^ (mw[t-15] >> 3))
                  + mw[t-16];
        end
    endtask

    task automatic build_model(input logic [511:0] blk, input int n);
        fill_model(blk);
        exp_q.delete();
        for (int t = 0; t < n; t++) exp_q.push_back(mw[t]);
    endtask

    // Called at a negedge; returns at the negedge where word 0 should be visible.
    task automatic accept_blk(input logic [511:0] blk, input bit keep_valid);
        int g;
        g = 0;
        block_in = blk;
        in_valid = 1'b1;
        while (!in_ready && g < 200) begin
            @(negedge CLK);
            g++;
        end
        if (g >= 200) check("accept_timeout", 1, 0);
        @(negedge CLK);
        if (!keep_valid) in_valid = 1'b0;
        check("first_valid", out_valid, 1);
        check("first_idx", out_idx, 0);
        check("busy_run", busy, 1);
    endtask

    // Drives out_ready per mode and scores every beat against exp_q.
    task automatic run_stream(input int mode, input int max_beats, output int run_cycles);
        int g, beats, exp_idx;
        logic r, stalled;
        logic [31:0] h_w;
        logic [5:0] h_idx;
        logic [31:0] e;
        g = 0; beats = 0; exp_idx = 0; stalled = 1'b0; run_cycles = 0;
        h_w = '0; h_idx = '0;
        while (g < 1000) begin
            g++;
            if (!out_valid) begin
                check("stream_valid", out_valid, 1);
                break;
            end
            run_cycles++;
            if (stalled) begin
                check("stall_w", out_w, h_w);
                check("stall_idx", out_idx, h_idx);
            end
            case (mode)
                0: r = 1'b1;
                1: r = (run_cycles % 2) == 1;
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            if (r) begin
                e = exp_q.pop_front();
                check("beat_w", out_w, e);
                check("beat_idx", out_idx, exp_idx);
                check("beat_last", out_last, exp_idx == 63);
                got_w[exp_idx] = out_w;
                exp_idx++;
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                h_w = out_w;
                h_idx = out_idx;
            end
            @(negedge CLK);
            if (beats == max_beats) break;
        end
        out_ready = 1'b0;
        if (g >= 1000) check("stream_timeout", 1, 0);
    endtask

    initial begin
        int cyc, g;
        logic [511:0] seq_blk;

        for (int i = 0; i < 16; i++) seq_blk[511 - 32*i -: 32] = 32'h10203040 + 32'h01010101 * i;

        hand_tbl[0] = '{0,  32'h61626380};
        hand_tbl[1] = '{1,  32'h00000000};
        hand_tbl[2] = '{14, 32'h00000000};
        hand_tbl[3] = '{15, 32'h00000018};
        hand_tbl[4] = '{16, 32'h61626380};
        hand_tbl[5] = '{17, 32'h000F0000};
        hand_tbl[6] = '{18, 32'h7DA86405};

        run_tbl[0] = '{ABC_BLK, 0};
        run_tbl[1] = '{ABC_BLK, 1};
        run_tbl[2] = '{seq_blk, 2};
        run_tbl[3] = '{{512{1'b1}}, 0};

        // Reset
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_w", out_w, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge CLK);

        // Table-driven full blocks
        for (int i = 0; i < 4; i++) begin
            build_model(run_tbl[i].blk, 64);
            accept_blk(run_tbl[i].blk, 1'b0);
            run_stream(run_tbl[i].mode, 64, cyc);
            check("end_out_valid", out_valid, 0);
            check("end_in_ready", in_ready, 1);
            check("end_busy", busy, 0);
            if (run_tbl[i].mode == 0) check("cycles_full_rate", cyc, 64);
            if (run_tbl[i].mode == 1) check("cycles_toggle_plus_idle", cyc + 1, 128);
            if (i == 0) begin
                for (int k = 0; k < 7; k++)
                    check($sformatf("abc_w%0d", hand_tbl[k].idx), got_w[hand_tbl[k].idx], hand_tbl[k].w);
            end
            @(negedge CLK);
        end

        // Abort at idx 20 while a beat is offered
        build_model(ABC_BLK, 64);
        accept_blk(ABC_BLK, 1'b0);
        run_stream(0, 20, cyc);
        check("abort_at_idx", out_idx, 20);
        abort = 1'b1;
        out_ready = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        out_ready = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_idx_held", out_idx, 20);
        build_model(seq_blk, 64);
        accept_blk(seq_blk, 1'b0);
        run_stream(0, 64, cyc);
        check("post_abort_in_ready", in_ready, 1);
        @(negedge CLK);

        // Reset pulse at idx 40
        build_model(ABC_BLK, 64);
        accept_blk(ABC_BLK, 1'b0);
        run_stream(0, 40, cyc);
        check("rst_at_idx", out_idx, 40);
        RST = 1'b1;
        out_ready = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        out_ready = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_w", out_w, 0);
        check("midrst_out_idx", out_idx, 0);
        check("midrst_out_last", out_last, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        build_model(ABC_BLK, 64);
        accept_blk(ABC_BLK, 1'b0);
        run_stream(0, 64, cyc);
        check("post_rst_w16", got_w[16], 32'h61626380);
        @(negedge CLK);

        // Back-to-back with in_valid held high; B offered during RUN of A
        build_model({512{1'b1}}, 64);
        accept_blk({512{1'b1}}, 1'b1);
        block_in = seq_blk;
        run_stream(0, 64, cyc);
        check("b2b_idle_in_ready", in_ready, 1);
        check("b2b_idle_out_valid", out_valid, 0);
        build_model(seq_blk, 64);
        @(negedge CLK);
        in_valid = 1'b0;
        check("b2b_second_valid", out_valid, 1);
        check("b2b_second_idx", out_idx, 0);
        run_stream(0, 64, cyc);
        check("b2b_end_in_ready", in_ready, 1);
        @(negedge CLK);

        // ROUNDS = 17 instance
        fill_model(ABC_BLK);
        block_in = ABC_BLK;
        in_valid17 = 1'b1;
        g = 0;
        while (!in_ready17 && g < 200) begin
            @(negedge CLK);
            g++;
        end
        if (g >= 200) check("r17_accept_timeout", 1, 0);
        @(negedge CLK);
        in_valid17 = 1'b0;
        out_ready17 = 1'b1;
        for (int k = 0; k < 17; k++) begin
            check("r17_valid", out_valid17, 1);
            check("r17_w", out_w17, mw[k]);
            check("r17_idx", out_idx17, k);
            check("r17_last", out_last17, k == 16);
            @(negedge CLK);
        end
        out_ready17 = 1'b0;
        check("r17_w16_hand", mw[16], 32'h61626380);
        check("r17_end_valid", out_valid17, 0);
        check("r17_end_in_ready", in_ready17, 1);
        check("r17_end_busy", busy17, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
